// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scanner.
package seg_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
  localparam int unsigned MAX_DIGITS = 32;

  // Active-low one-hot anode pattern; callers truncate to their digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot_n(input logic [4:0] idx);
    return ~(32'd1 << idx);
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running slot prescaler: counts 0..PRESCALE-1 and flags the last count.
module seg_tick_gen #(
  parameter  int unsigned PRESCALE = 100000,
  localparam int unsigned CNT_W    = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             tick_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o  = (cnt_q == LAST);
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit common-anode scanner with double-buffered word,
// anti-ghost guard interval, leading-zero blanking and per-digit enable.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned GUARD    = 4,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DIGIT_W*DIGITS-1:0] value,
  input  logic                      load,
  input  logic [DIGITS-1:0]         en_mask,
  output logic [DIGIT_W-1:0]        digit,
  output logic [DIGITS-1:0]         an,
  output logic                      pending,
  output logic                      frame_start
);

  localparam int unsigned CNT_W  = $clog2(PRESCALE);
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned WORD_W = DIGIT_W * DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);

  logic             tick;
  logic [CNT_W-1:0] cnt;

  seg_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_o  (tick),
    .count_o (cnt)
  );

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  shadow_q, shadow_d;
  logic [WORD_W-1:0]  active_q, active_d;
  logic               pending_q, pending_d;
  logic               frame_q, frame_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;

  logic               wrap;
  logic [DIGITS-1:0]  lz_zero;
  logic [DIGIT_W-1:0] nib;
  logic               blank;

  assign wrap = tick && (idx_q == IDX_LAST);

  // A load on the wrap edge bypasses the shadow so it shows this very frame.
  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    shadow_d  = load ? value : shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wrap) begin
      pending_d = 1'b0;
      if (load) begin
        active_d = value;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
    frame_d = wrap;
  end

  always_comb begin
    lz_zero = '0;
    for (int unsigned s = 0; s < DIGITS; s++) begin
      lz_zero[s] = ((active_q >> (s * DIGIT_W)) == '0);
    end
    nib = BLANK_CODE;
    for (int unsigned s = 0; s < DIGITS; s++) begin
      if (idx_q == IDX_W'(s)) begin
        nib = active_q[s*DIGIT_W +: DIGIT_W];
      end
    end
    blank = (cnt < GUARD_C) || !en_mask[idx_q] ||
            (LZ_BLANK && (idx_q != '0) && lz_zero[idx_q]);
    an_d    = '1;
    digit_d = BLANK_CODE;
    if (!blank) begin
      an_d    = DIGITS'(onehot_n(5'(idx_q)));
      digit_d = nib;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      an_q      <= '1;
      digit_q   <= BLANK_CODE;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      an_q      <= an_d;
      digit_q   <= digit_d;
    end
  end

  assign an          = an_q;
  assign digit       = digit_q;
  assign pending     = pending_q;
  assign frame_start = frame_q;

endmodule
